// File: rtl/oka_product_accumulator.sv
// Multiply-accumulate back end for OKA_32bit: sums a programmed number of
// products from a valid/ready stream and holds the total for a downstream sink.
module oka_product_accumulator #(
  parameter int PW = 63,
  parameter int AW = 72,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          p_valid,
  input  logic [PW-1:0] p_data,
  output logic          p_ready,
  output logic          res_valid,
  output logic [AW-1:0] res_data,
  input  logic          res_ready,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] res_q, res_d;
  logic          ovf_q, ovf_d;
  logic          res_valid_q, res_valid_d;

  // One extra bit captures the carry out of the AW-bit add.
  logic [AW:0]   sum_w;
  logic [LW-1:0] cnt_inc_w;

  assign sum_w     = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, p_data};
  assign cnt_inc_w = cnt_q + LW'(1);

  assign p_ready   = (state_q == ST_ACC);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_q;
  assign overflow  = ovf_q;

  always_comb begin
    // NOTE: every next-state variable takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (len != LW'(0)) begin
            len_d   = len;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_ACC;
          end else begin
            res_d       = '0;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_ACC: begin
        if (p_valid) begin
          acc_d = sum_w[AW-1:0];
          cnt_d = cnt_inc_w;
          if (sum_w[AW]) ovf_d = 1'b1;
          // Last beat: publish the sum directly so res_valid lands next cycle.
          if (cnt_inc_w == len_q) begin
            res_d       = sum_w[AW-1:0];
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_oka_product_accumulator.sv
// Self-checking bench for oka_product_accumulator (64-bit accumulator build):
// directed scenarios plus randomized runs scored against an arithmetic model.
module tb_oka_product_accumulator;

  localparam int PW = 63;
  localparam int AW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          p_valid;
  logic [PW-1:0] p_data;
  logic          p_ready;
  logic          res_valid;
  logic [AW-1:0] res_data;
  logic          res_ready;
  logic          overflow;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [PW-1:0] prod_q[$];

  oka_product_accumulator #(.PW(PW), .AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_prod();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // Runs one accumulation of the products in prod_q. gap >= 0 inserts that
  // many idle cycles before each beat after the first; gap < 0 stalls randomly.
  task automatic do_run(input int gap, input int hold_wait, input bit poke_start);
    logic [79:0]   total;
    logic [AW-1:0] exp_res;
    logic          exp_ovf;
    int            n;
    int            idx;
    int            cycles;
    int            idle_left;
    bit            accepted;

    n = prod_q.size();
    total = '0;
    foreach (prod_q[i]) total += 80'(prod_q[i]);
    exp_res = total[AW-1:0];
    exp_ovf = |total[79:AW];

    start = 1'b1;
    len   = LW'(n);
    step();
    start = 1'b0;
    len   = LW'($urandom);

    if (n == 0) begin
      check("zero_len_valid", 80'(res_valid), 80'(1));
      check("zero_len_ready", 80'(p_ready), 80'(0));
    end else begin
      check("start_p_ready", 80'(p_ready), 80'(1));
      check("start_busy", 80'(busy), 80'(1));
      idx = 0;
      cycles = 0;
      idle_left = 0;
      while (idx < n && cycles < 4000) begin
        if (idle_left > 0) begin
          p_valid = 1'b0;
          p_data  = rand_prod();
          idle_left--;
        end else begin
          p_valid = 1'b1;
          p_data  = prod_q[idx];
        end
        if (poke_start && idx == 1) begin
          start = 1'b1;
          len   = LW'(9);
        end
        accepted = p_valid && p_ready;
        step();
        start = 1'b0;
        cycles++;
        if (accepted) begin
          idx++;
          idle_left = (gap >= 0) ? gap : int'($urandom_range(0, 2));
          if (idx < n) check("acc_no_result", 80'(res_valid), 80'(0));
        end
      end
      if (idx < n) check("beat_timeout", 80'(idx), 80'(n));
      check("last_p_ready", 80'(p_ready), 80'(0));
    end

    check("res_valid", 80'(res_valid), 80'(1));
    check("res_data", 80'(res_data), 80'(exp_res));
    check("overflow", 80'(overflow), 80'(exp_ovf));

    // Extra beats offered while holding must never be taken.
    for (int k = 0; k < hold_wait; k++) begin
      res_ready = 1'b0;
      p_valid   = 1'b1;
      p_data    = rand_prod();
      step();
      check("hold_valid", 80'(res_valid), 80'(1));
      check("hold_data", 80'(res_data), 80'(exp_res));
      check("hold_p_ready", 80'(p_ready), 80'(0));
    end
    p_valid   = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("idle_busy", 80'(busy), 80'(0));
    check("idle_valid", 80'(res_valid), 80'(0));
    check("idle_data_kept", 80'(res_data), 80'(exp_res));
    check("idle_ovf_kept", 80'(overflow), 80'(exp_ovf));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    p_valid   = 1'b0;
    p_data    = '0;
    res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_p_ready", 80'(p_ready), 80'(0));
    check("rst_valid", 80'(res_valid), 80'(0));
    check("rst_data", 80'(res_data), 80'(0));
    check("rst_ovf", 80'(overflow), 80'(0));

    // Basic sum, no stalls.
    prod_q = '{63'd6, 63'd10, 63'd15};
    do_run(0, 0, 1'b0);

    // Stalls between beats and result backpressure.
    prod_q = '{63'd7, 63'd9};
    do_run(3, 4, 1'b0);

    // Zero length.
    prod_q = {};
    do_run(0, 2, 1'b0);

    // Wrap with sticky overflow, then a clean run clears it.
    prod_q = '{63'h7FFF_FFFF_FFFF_FFFF, 63'h7FFF_FFFF_FFFF_FFFF, 63'd2};
    do_run(0, 1, 1'b0);
    prod_q = '{63'd5};
    do_run(0, 0, 1'b0);

    // Reset in the middle of an accumulation.
    start = 1'b1;
    len   = LW'(4);
    step();
    start   = 1'b0;
    p_valid = 1'b1;
    p_data  = 63'd11;
    step();
    p_data  = 63'd12;
    step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    p_valid = 1'b0;
    check("midrst_busy", 80'(busy), 80'(0));
    check("midrst_p_ready", 80'(p_ready), 80'(0));
    check("midrst_valid", 80'(res_valid), 80'(0));
    check("midrst_data", 80'(res_data), 80'(0));
    prod_q = '{63'd3};
    do_run(0, 0, 1'b0);

    // start during ACC is ignored.
    prod_q = '{63'd1, 63'd2};
    do_run(0, 2, 1'b1);

    // Maximum length with large products.
    prod_q = {};
    for (int i = 0; i < 255; i++) prod_q.push_back(rand_prod() | 63'h4000_0000_0000_0000);
    do_run(-1, 1, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      prod_q = {};
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) prod_q.push_back(rand_prod());
      do_run(-1, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
